// File: rtl/vit_frame_ctrl.sv
// Purpose: gathers N soft symbols per frame, holds them steady for the (8,4) decoder, captures its message.
// Latency: message is valid in the (SETTLE+1)th cycle after the cycle that accepts the last symbol.
// Backpressure: in_ready is low while settling; a full output register stalls the controller in SETTLE.
module vit_frame_ctrl #(
    parameter int W      = 6,
    parameter int N      = 8,
    parameter int K      = 4,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_sym,
    input  logic                in_sof,
    output logic [N*W-1:0]      dec_r,
    input  logic [K-1:0]        dec_m,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [K-1:0]        out_m,
    output logic [15:0]         frame_cnt,
    output logic [7:0]          resync_cnt
);
    localparam int              IDXW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

    typedef enum logic {S_COLLECT, S_SETTLE} state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [3:0]      wait_q;
    logic [N*W-1:0]  slots_q;
    logic            out_valid_q;
    logic [K-1:0]    out_m_q;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [7:0]      resync_cnt_q, resync_cnt_d;

    logic            accept;
    logic            frame_end;
    logic            out_hs;
    logic            capture;
    logic [IDXW-1:0] wr_idx;

    // A start-of-frame flag always realigns the write pointer to slot 0.
    assign in_ready  = (state_q == S_COLLECT);
    assign accept    = in_valid && in_ready;
    assign wr_idx    = in_sof ? '0 : idx_q;
    assign frame_end = accept && (wr_idx == LAST_IDX);
    assign out_hs    = out_valid_q && out_ready;
    // Sample the decoder only once settled and only if the output register is (or is becoming) free.
    assign capture   = (state_q == S_SETTLE) && (wait_q == 4'd1) && (!out_valid_q || out_ready);

    assign dec_r      = slots_q;
    assign out_valid  = out_valid_q;
    assign out_m      = out_m_q;
    assign frame_cnt  = frame_cnt_q;
    assign resync_cnt = resync_cnt_q;

    // Frame sequencer: collect symbols, settle the decoder, capture into the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_COLLECT;
            idx_q       <= '0;
            wait_q      <= 4'd0;
            slots_q     <= '0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < N; i++) begin
                            if (wr_idx == IDXW'(i)) begin
                                slots_q[i*W +: W] <= in_sym;
                            end
                        end
                        if (frame_end) begin
                            idx_q   <= '0;
                            wait_q  <= SETTLE_LD;
                            state_q <= S_SETTLE;
                        end else begin
                            idx_q <= wr_idx + IDXW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (wait_q > 4'd1) begin
                        wait_q <= wait_q - 4'd1;
                    end else if (capture) begin
                        out_m_q <= dec_m;
                        state_q <= S_COLLECT;
                    end
                end
                default: state_q <= S_COLLECT;
            endcase

            // A capture on the same edge as a handshake keeps the register full with the new message.
            if (capture) begin
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Next-state for the statistics counters: delivered frames wrap, resyncs saturate.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        resync_cnt_d = resync_cnt_q;
        if (out_hs) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (accept && in_sof && (idx_q != '0) && (resync_cnt_q != 8'hFF)) begin
            resync_cnt_d = resync_cnt_q + 8'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q  <= 16'd0;
            resync_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Bench for vit_frame_ctrl with a sign-bit decoder stub on dec_r/dec_m.
// Driver keeps a frame-level model and queues expected messages; a monitor pops them on each out handshake.
module tb_vit_frame_ctrl;
    localparam int W      = 6;
    localparam int N      = 8;
    localparam int K      = 4;
    localparam int SETTLE = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_sym;
    logic                in_sof;
    logic [N*W-1:0]      dec_r;
    logic [K-1:0]        dec_m;
    logic                out_valid;
    logic                out_ready;
    logic [K-1:0]        out_m;
    logic [15:0]         frame_cnt;
    logic [7:0]          resync_cnt;

    vit_frame_ctrl #(.W(W), .N(N), .K(K), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_sof(in_sof),
        .dec_r(dec_r), .dec_m(dec_m),
        .out_valid(out_valid), .out_ready(out_ready), .out_m(out_m),
        .frame_cnt(frame_cnt), .resync_cnt(resync_cnt)
    );

    // Decoder stub: message bit i is the sign of slot i.
    for (genvar g = 0; g < K; g++) begin : g_stub
        assign dec_m[g] = dec_r[g*W + W - 1];
    end

    always #5 clk = ~clk;

    int           n_cmp  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    logic [K-1:0] exp_q[$];
    logic [W-1:0] m_slots[N];
    int           m_idx       = 0;
    int           m_resync    = 0;
    logic [15:0]  exp_frames  = 16'd0;
    bit           armed       = 1'b0;
    int           acc_cyc     = 0;
    bit           rand_rdy    = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pack_model();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = m_slots[i];
        return r;
    endfunction

    function automatic logic [K-1:0] model_msg();
        logic [K-1:0] m;
        for (int i = 0; i < K; i++) m[i] = m_slots[i][W-1];
        return m;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < N; i++) m_slots[i] = '0;
        m_idx      = 0;
        m_resync   = 0;
        exp_frames = 16'd0;
        armed      = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Offer one symbol, wait (bounded) for it to be accepted, update the model, then idle 'gap' cycles.
    task automatic send(input int s, input bit sof, input int gap);
        int n;
        logic [W-1:0] sv;
        sv       = s[W-1:0];
        in_valid = 1'b1;
        in_sym   = sv;
        in_sof   = sof;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            sync();
            return;
        end
        if (sof) begin
            if (m_idx != 0 && m_resync < 255) m_resync++;
            m_slots[0] = sv;
            m_idx = 1;
        end else begin
            m_slots[m_idx] = sv;
            m_idx++;
        end
        if (m_idx == N) begin
            m_idx = 0;
            exp_q.push_back(model_msg());
            acc_cyc = cyc;
            armed   = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) sync();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            sync();
            n++;
        end
        check("drain_timeout", (exp_q.size() != 0 || out_valid) ? 1 : 0, 0);
    endtask

    function automatic int rsym();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -32;
        if (r == 1) return 31;
        return int'($urandom_range(0, 63)) - 32;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: settle/latency timing, output stability, and scoreboard pops on every handshake.
    initial begin
        bit           prev_ov  = 1'b0;
        bit           prev_rdy = 1'b0;
        logic [K-1:0] prev_m   = '0;
        logic [K-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov  = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (armed && cyc > acc_cyc && cyc <= acc_cyc + SETTLE)
                    check("in_ready_settle", in_ready, 0);
                if (prev_ov && !prev_rdy) begin
                    check("out_hold_vld", out_valid, 1);
                    check("out_hold_m", out_m, prev_m);
                end
                if (out_valid && !prev_ov && armed) begin
                    check("latency", cyc - acc_cyc, SETTLE + 1);
                    armed = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_m", out_m, e);
                        check("frame_cnt_hs", frame_cnt, exp_frames);
                        exp_frames = exp_frames + 16'd1;
                    end
                end
                prev_ov  = out_valid;
                prev_rdy = out_ready;
                prev_m   = out_m;
            end
        end
    end

    int basic[N] = '{-5, 7, -1, 3, 0, 31, -32, 2};

    initial begin
        in_valid  = 1'b0;
        in_sym    = '0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        clear_model();
        repeat (2) sync();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_m", out_m, 0);
        check("rst_dec_r", dec_r, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_resync_cnt", resync_cnt, 0);
        sync();

        // Basic frame
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(basic[i], i == 0, 0);
        drain();
        check("basic_out_m", out_m, 4'h5);
        check("basic_frame_cnt", frame_cnt, 1);
        check("basic_dec_r", dec_r, pack_model());

        // Backpressure: two frames, sink stalled
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(basic[i], i == 0, 0);
        for (int i = 0; i < N; i++) send(4, i == 0, 0);
        repeat (6) sync();
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_m", out_m, 4'h5);
        check("bp_frame_cnt", frame_cnt, 1);
        sync();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_cont_valid", out_valid, 1);
        check("bp_cont_m", out_m, 4'h0);
        check("bp_cont_cnt", frame_cnt, 2);
        sync();
        out_ready = 1'b1;
        drain();
        check("bp_final_cnt", frame_cnt, 3);

        // Resync mid-frame
        send(-1, 1'b1, 0);
        send(1, 1'b0, 0);
        send(1, 1'b0, 0);
        send(3, 1'b1, 0);
        send(-4, 1'b0, 0);
        send(-9, 1'b0, 0);
        send(6, 1'b0, 0);
        for (int i = 0; i < 4; i++) send(rsym(), 1'b0, 0);
        drain();
        check("resync_cnt_1", resync_cnt, 1);
        check("resync_out_m", out_m, 4'h6);

        // Input gaps (in_valid 1010...)
        for (int i = 0; i < N; i++) send(basic[i], i == 0, 1);
        drain();
        check("gap_out_m", out_m, 4'h5);
        check("gap_dec_r", dec_r, pack_model());

        // Reset while settling
        for (int i = 0; i < N; i++) send(basic[i], i == 0, 0);
        do_reset();
        @(negedge clk);
        check("rstset_out_valid", out_valid, 0);
        check("rstset_dec_r", dec_r, 0);
        check("rstset_frame_cnt", frame_cnt, 0);
        sync();
        repeat (5) sync();
        check("rstset_no_output", out_valid, 0);
        for (int i = 0; i < N; i++) send(-1, i == 0, 0);
        drain();
        check("rstset_next_m", out_m, 4'hF);
        check("rstset_next_cnt", frame_cnt, 1);

        // Randomized frames, random sink readiness, occasional mid-frame resyncs
        rand_rdy = 1'b1;
        for (int k = 0; k < 320; k++) begin
            send(rsym(), (m_idx == 0) || ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        while (m_idx != 0) send(rsym(), 1'b0, 0);
        rand_rdy = 1'b0;
        sync();
        out_ready = 1'b1;
        drain();
        check("rand_resync_cnt", resync_cnt, m_resync);
        check("rand_frame_cnt", frame_cnt, exp_frames);
        check("rand_dec_r", dec_r, pack_model());

        // Resync counter saturation
        do_reset();
        for (int k = 0; k < 201; k++) send(rsym(), 1'b1, 0);
        @(negedge clk);
        check("resync_200", resync_cnt, m_resync);
        sync();
        for (int k = 0; k < 60; k++) send(rsym(), 1'b1, 0);
        @(negedge clk);
        check("resync_sat", resync_cnt, 255);
        check("resync_sat_model", resync_cnt, m_resync);
        sync();

        // Frame counter wrap
        do_reset();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        exp_frames = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        check("wrap_preload", frame_cnt, 16'hFFFF);
        sync();
        for (int i = 0; i < N; i++) send(5, i == 0, 0);
        drain();
        check("wrap_zero", frame_cnt, 0);
        for (int i = 0; i < N; i++) send(-20, i == 0, 0);
        drain();
        check("wrap_one", frame_cnt, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
